// File: rtl/turf_ram_scheduler_if.sv
// RAM port bundle between the turf scheduler (master) and the turf RAM (slave).
interface turf_ram_scheduler_if #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned COLOR_W = 3
);
  logic [ADDR_W-1:0]  ram_address;
  logic [COLOR_W-1:0] ram_data;
  logic               ram_wren;
  logic [COLOR_W-1:0] ram_q;

  modport master (
    output ram_address,
    output ram_data,
    output ram_wren,
    input  ram_q
  );

  modport slave (
    input  ram_address,
    input  ram_data,
    input  ram_wren,
    output ram_q
  );
endinterface

// File: rtl/turf_ram_scheduler.sv
// Turf RAM scheduler: per move tick, read-check then paint each active player's head cell in
// strict p1..p4 order; also runs the full-board clear sweep. Sole master of the RAM port.
module turf_ram_scheduler #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned COLOR_W    = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  clear_req,
  input  logic [3:0]            active,
  input  logic [4*ADDR_W-1:0]   pos,
  turf_ram_scheduler_if.master  ram,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            hit,
  output logic                  clear_done,
  output logic                  overrun
);

  typedef enum logic [2:0] {StIdle, StSel, StWait, StWrite, StDone, StClear} state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q;
  logic [1:0]          lat_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [3:0]          active_snap_q;
  logic [4*ADDR_W-1:0] pos_snap_q;
  logic [3:0]          hit_q;
  logic                overrun_q;
  logic                clear_pend_q;
  logic                clear_done_q;

  logic [ADDR_W-1:0]   cur_addr;
  logic                lat_last;
  logic                clr_last;
  logic                clear_go;
  logic                in_frame;

  assign lat_last = (lat_q == 2'(RD_LATENCY - 1));
  assign clr_last = &clr_cnt_q;
  assign clear_go = clear_req | clear_pend_q;
  assign in_frame = (state_q == StSel) || (state_q == StWait) ||
                    (state_q == StWrite) || (state_q == StDone);

  // Select the snapshotted head position of the player currently being serviced.
  always_comb begin
    cur_addr = '0;
    unique case (idx_q)
      2'd0: cur_addr = pos_snap_q[0*ADDR_W +: ADDR_W];
      2'd1: cur_addr = pos_snap_q[1*ADDR_W +: ADDR_W];
      2'd2: cur_addr = pos_snap_q[2*ADDR_W +: ADDR_W];
      2'd3: cur_addr = pos_snap_q[3*ADDR_W +: ADDR_W];
      default: cur_addr = '0;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clear_go) begin
          state_d = StClear;
        end else if (tick) begin
          state_d = StSel;
        end
      end
      StSel: begin
        if (active_snap_q[idx_q]) begin
          state_d = StWait;
        end else if (idx_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (lat_last) begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = (idx_q == 2'd3) ? StDone : StSel;
      StDone:  state_d = StIdle;
      StClear: begin
        if (clr_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: snapshots, player index, read-latency counter, hit flags, clear counter, flags.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idx_q         <= '0;
      lat_q         <= '0;
      clr_cnt_q     <= '0;
      active_snap_q <= '0;
      pos_snap_q    <= '0;
      hit_q         <= '0;
      overrun_q     <= 1'b0;
      clear_pend_q  <= 1'b0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      // Ticks and clears arriving mid-frame: tick is dropped but flagged, clear is deferred.
      if (in_frame && tick) begin
        overrun_q <= 1'b1;
      end
      if (in_frame && clear_req) begin
        clear_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (clear_go) begin
            clear_pend_q <= 1'b0;
            clr_cnt_q    <= '0;
          end else if (tick) begin
            active_snap_q <= active;
            pos_snap_q    <= pos;
            hit_q         <= '0;
            idx_q         <= '0;
          end
        end
        StSel: begin
          lat_q <= '0;
          // Inactive player: skip in one cycle; idx wraps to 0 after the last player.
          if (!active_snap_q[idx_q]) begin
            idx_q <= idx_q + 2'd1;
          end
        end
        StWait: begin
          if (lat_last) begin
            hit_q[idx_q] <= |ram.ram_q;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        StWrite: idx_q <= idx_q + 2'd1;
        StClear: begin
          if (clr_last) begin
            clear_done_q <= 1'b1;
            overrun_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the RAM is idle (wren=0, data=0) except in WRITE and CLEAR.
  always_comb begin
    ram.ram_address = '0;
    ram.ram_data    = '0;
    ram.ram_wren    = 1'b0;
    unique case (state_q)
      StSel: begin
        if (active_snap_q[idx_q]) begin
          ram.ram_address = cur_addr;
        end
      end
      StWait: ram.ram_address = cur_addr;
      StWrite: begin
        ram.ram_address = cur_addr;
        ram.ram_data    = COLOR_W'(idx_q) + COLOR_W'(1);
        ram.ram_wren    = 1'b1;
      end
      StClear: begin
        ram.ram_address = clr_cnt_q;
        ram.ram_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign hit        = hit_q;
  assign clear_done = clear_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_turf_ram_scheduler.sv
// Scoreboard bench for turf_ram_scheduler: a behavioural turf-board model predicts every RAM
// write and every frame's hit vector; a monitor compares them against what the DUT presents.
module tb_turf_ram_scheduler;
  localparam int AW = 15;
  localparam int CW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          clear_req = 1'b0;
  logic [3:0]    active = '0;
  logic [4*AW-1:0] pos = '0;
  logic          busy, done, clear_done, overrun;
  logic [3:0]    hit;

  turf_ram_scheduler_if #(.ADDR_W(AW), .COLOR_W(CW)) ram_if ();

  turf_ram_scheduler #(.RD_LATENCY(1), .ADDR_W(AW), .COLOR_W(CW)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .clear_req  (clear_req),
    .active     (active),
    .pos        (pos),
    .ram        (ram_if),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .clear_done (clear_done),
    .overrun    (overrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // RAM with one clock of read latency.
  logic [CW-1:0] mem [32768];
  always @(posedge CLOCK_50) begin
    if (ram_if.ram_wren) mem[ram_if.ram_address] <= ram_if.ram_data;
    ram_if.ram_q <= mem[ram_if.ram_address];
  end

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] ref_mem [32768];
  logic [AW+CW-1:0] wq [$];
  logic [3:0] hq [$];
  bit chk_writes = 1'b1;
  int clear_done_seen = 0;
  logic [AW+CW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the predicted queues.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (clear_done) clear_done_seen++;
      if (chk_writes && ram_if.ram_wren) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'({ram_if.ram_address, ram_if.ram_data}), 32'hFFFF_FFFF);
        end else begin
          mon_e = wq.pop_front();
          check("write", 32'({ram_if.ram_address, ram_if.ram_data}), 32'(mon_e));
        end
      end
      if (done) begin
        if (hq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("hit", 32'(hit), 32'(hq.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLOCK_50);
    while (busy && n < 40000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Run one frame: predict hits/writes from the board model, then drive the tick.
  task automatic frame(input logic [3:0] act, input logic [4*AW-1:0] p,
                       input bit extra_tick, input bit extra_clear);
    logic [3:0] eh = '0;
    int exp_n = 1;
    int n;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = p[i*AW +: AW];
      if (act[i]) begin
        if (ref_mem[a] != 0) eh[i] = 1'b1;
        ref_mem[a] = CW'(i + 1);
        wq.push_back({a, CW'(i + 1)});
        exp_n += 3;
      end else begin
        exp_n += 1;
      end
    end
    hq.push_back(eh);
    if (extra_clear) begin
      for (int k = 0; k < 32768; k++) begin
        wq.push_back({AW'(k), CW'(0)});
        ref_mem[k] = '0;
      end
    end
    wait_idle();
    active = act;
    pos    = p;
    tick   = 1'b1;
    @(posedge CLOCK_50);
    #1 tick = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(posedge CLOCK_50);
      #1;
      n++;
      if (extra_tick) tick = (n == 3);
      if (extra_clear) clear_req = (n == 2);
    end
    tick      = 1'b0;
    clear_req = 1'b0;
    check("done_latency", 32'(n), 32'(exp_n));
  endtask

  function automatic logic [4*AW-1:0] rand_pos();
    logic [4*AW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*AW +: AW] = AW'($urandom_range(0, 7) * 32'h0421);
    return r;
  endfunction

  initial begin
    int n;
    int nz;
    for (int k = 0; k < 32768; k++) begin
      mem[k]     = '0;
      ref_mem[k] = '0;
    end
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_wren", 32'(ram_if.ram_wren), 32'd0);
    check("rst_addr", 32'(ram_if.ram_address), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    @(negedge CLOCK_50) reset = 1'b0;

    // Single player on an empty cell, then again on its own trail.
    frame(4'b0001, {45'd0, 15'h1234}, 1'b0, 1'b0);
    check("t1_hit", 32'(hit), 32'h0);
    frame(4'b0001, {45'd0, 15'h1234}, 1'b0, 1'b0);
    check("t2_hit", 32'(hit), 32'h1);
    @(negedge CLOCK_50);
    check("t2_cell", 32'(mem[15'h1234]), 32'd1);
    // Two players into the same empty cell: the lower index wins.
    frame(4'b0011, {30'd0, 15'h0500, 15'h0500}, 1'b0, 1'b0);
    check("t3_hit", 32'(hit), 32'h2);
    // Nobody active.
    frame(4'b0000, rand_pos(), 1'b0, 1'b0);
    check("t4_hit", 32'(hit), 32'h0);

    for (int r = 0; r < 25; r++) frame(4'($urandom), rand_pos(), 1'b0, 1'b0);
    check("overrun_clean", 32'(overrun), 32'd0);

    // Tick mid-frame is dropped and flagged.
    frame(4'b1111, rand_pos(), 1'b1, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);

    // Clear requested mid-frame runs after the frame; a tick inside the sweep is ignored.
    frame(4'b1011, rand_pos(), 1'b0, 1'b1);
    repeat (100) @(negedge CLOCK_50);
    check("clear_busy", 32'(busy), 32'd1);
    tick = 1'b1;
    @(negedge CLOCK_50) tick = 1'b0;
    n = 0;
    while (clear_done_seen == 0 && n < 40000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("clear_done_seen", 32'(clear_done_seen), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    check("clear_done_once", 32'(clear_done_seen), 32'd1);
    check("clear_overrun", 32'(overrun), 32'd0);
    check("clear_idle", 32'(busy), 32'd0);
    nz = 0;
    for (int k = 0; k < 32768; k++) if (mem[k] != 0) nz++;
    check("clear_readback", 32'(nz), 32'd0);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("hq_empty", 32'(hq.size()), 32'd0);

    // Reset during a sweep aborts immediately.
    chk_writes = 1'b0;
    clear_req = 1'b1;
    @(negedge CLOCK_50) clear_req = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    check("preabort_wren", 32'(ram_if.ram_wren), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_wren", 32'(ram_if.ram_wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(ram_if.ram_address), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("post_abort_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
